fix_addsub_pipe: RTL and testbench
==================================

Name: fix_addsub_pipe

Overview:
Parametrised, multi-lane, pipelined two's-complement fixed-point adder/subtractor for the FFT datapath, used for butterfly sum/difference.
- Every lane computes a+b or a−b in Q(WIDTH−FRAC).FRAC with a valid/ready handshake and backpressure.
- Per-lane overflow flags and a saturating overflow-event counter feed debug and scaling control.
- Replaces the single-lane, unregistered, no-backpressure adder.

Parameters:
- WIDTH, 16, total word width per lane, including sign (legal range 4..32).
- FRAC, 7, fractional bits. Informational only; does not affect arithmetic (FRAC < WIDTH).
- LANES, 2, independent parallel lanes sharing one handshake.
- STAGES, 2, pipeline register depth, legal range 1..4.
- CNT_W, 16, width of the overflow-event counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  block can accept a beat this cycle.
- sub  in  LANES  per-lane mode: 0 gives a+b, 1 gives a−b. Sampled with the beat.
- a  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH], two's complement.
- b  in  LANES*WIDTH  same packing as a.
- out_vld  out  1  result beat valid.
- out_rdy  in  1  downstream accepts the result.
- r  out  LANES*WIDTH  results, packed the same way as a.
- ovf  out  LANES  per-lane overflow flag, aligned with r.
- ovf_sticky  out  1  set by any accepted overflowing beat; cleared only by clr_stat or reset.
- ovf_cnt  out  CNT_W  count of accepted output beats with any ovf bit set.
- clr_stat  in  1  synchronous clear of ovf_sticky and ovf_cnt.

Behaviour:
- Reset: clk is the clock; rstn is asynchronous, active-low. While rstn is low, all stage valid bits, r, ovf, out_vld, ovf_sticky and ovf_cnt are 0.
  - Reset asserted mid-operation discards every in-flight beat.
  - in_rdy reads 1 one cycle after rstn deasserts.
- Input transfer: occurs when in_vld && in_rdy. Output transfer: occurs when out_vld && out_rdy.
- Pipeline structure:
  - STAGES register stages, each holding a valid bit plus payload. The last stage drives out_vld, r and ovf directly from registers.
  - Stage k loads when it is empty or stage k+1 loads this cycle. The last stage loads when it is empty or out_rdy is high.
  - in_rdy is the stage-0 load condition (combinational from out_rdy through the ready chain). Bubbles collapse.
- Latency: a beat accepted at edge n appears with out_vld=1 after edge n+STAGES−1, provided out_rdy was high throughout. Throughput is 1 beat per cycle.
- Capacity: exactly STAGES beats. With out_rdy low, in_rdy falls once all stages are valid.
- No loss or duplication: out_vld, r and ovf stay stable while out_vld && !out_rdy.
- Arithmetic, computed in stage 0, per lane:
  - Sign-extend a and b to WIDTH+1 bits.
  - s = a + b when sub=0, s = a + (~b) + 1 when sub=1.
  - ovf = s[WIDTH] ^ s[WIDTH−1]. This is also correct for b = −2^(WIDTH−1) with sub=1.
  - Result is s[WIDTH−1:0] (wrap), or the saturated value when the optional feature is enabled.
  - Later stages are pure delay registers.
- Statistics, evaluated on an output transfer where |ovf is true:
  - ovf_sticky is set to 1.
  - ovf_cnt increments by 1 and saturates at all-ones (no wrap).
- clr_stat: takes priority over a simultaneous event in the same cycle; the result is 0 and the event is dropped.
- Without a transfer, statistics hold their value.

Optional Feature:
Macro FIX_ADDSUB_SAT_EN.
- Defined: on overflow, the lane result is clamped to 2^(WIDTH−1)−1 when s[WIDTH]=0 (positive overflow) or to −2^(WIDTH−1) when s[WIDTH]=1. ovf is still asserted.
- Undefined: the result wraps to s[WIDTH−1:0] and ovf is asserted.
- Timing, handshake and statistics are identical in both builds.

Test Plan (WIDTH=16, FRAC=7, LANES=2, STAGES=2):
- Basic add: out_rdy=1; lane0 1.5+2.25 (0x00C0+0x0120, sub=0); lane1 −1.0−0.5 (0xFF80, 0x0040, sub=1) -> one cycle after acceptance, r lane0=0x01E0, lane1=0xFF40, ovf=00.
- Positive overflow: 0x7FFF+0x0001 -> ovf[0]=1; r=0x8000 wrap build, 0x7FFF with SAT_EN; ovf_sticky=1, ovf_cnt=1.
- Negative overflow and minimum-value subtract: 0x8000−0x0001 gives wrap 0x7FFF / sat 0x8000; 0x0000−0x8000 gives wrap 0x8000 / sat 0x7FFF; both with ovf=1.
- Backpressure: in_vld=1 streaming 0x0001..0x0010, out_rdy=0 for 6 cycles -> exactly 2 beats accepted, then in_rdy=0; r held stable. After out_rdy=1, all 16 results appear in order with none lost or duplicated.
- Statistics: CNT_W=4, 20 back-to-back overflowing beats -> ovf_cnt saturates at 0xF. clr_stat asserted in the same cycle as an overflowing transfer -> ovf_cnt=0, ovf_sticky=0.
- Reset mid-stream: assert rstn low with 2 beats in flight -> out_vld=0, r=0 immediately (asynchronous). After release, in_rdy=1 and no stale beat emerges.

Source files
------------

// File: rtl/fix_addsub_pipe_if.sv
// Handshake and data bundle for fix_addsub_pipe.
// Lanes are packed LSB-first: lane i occupies bits [i*WIDTH +: WIDTH].
// The master side feeds operands and consumes results.
// The slave side is the adder/subtractor pipeline.
interface fix_addsub_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
);
    logic                     in_vld;
    logic                     in_rdy;
    logic [LANES-1:0]         sub;
    logic [LANES*WIDTH-1:0]   a;
    logic [LANES*WIDTH-1:0]   b;
    logic                     out_vld;
    logic                     out_rdy;
    logic [LANES*WIDTH-1:0]   r;
    logic [LANES-1:0]         ovf;

    modport master (
        output in_vld, sub, a, b, out_rdy,
        input  in_rdy, out_vld, r, ovf
    );

    modport slave (
        input  in_vld, sub, a, b, out_rdy,
        output in_rdy, out_vld, r, ovf
    );
endinterface

// File: rtl/fix_addsub_pipe.sv
// Multi-lane pipelined two's-complement fixed-point adder/subtractor used for
// FFT butterfly sum/difference. The arithmetic happens in stage 0; later
// stages only delay the result. A valid/ready chain lets bubbles collapse and
// holds the output steady under backpressure.
// Optional build macro FIX_ADDSUB_SAT_EN: when defined, overflowing lanes clamp
// to the most positive/negative value instead of wrapping. ovf is raised in
// both builds.
module fix_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 7,
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    fix_addsub_pipe_if.slave     bus,
    input  logic                 clr_stat,
    output logic                 ovf_sticky,
    output logic [CNT_W-1:0]     ovf_cnt
);

    // FRAC only documents the Q format; the arithmetic is format-agnostic.
    if (STAGES < 1 || STAGES > 4 || WIDTH < 4 || WIDTH > 32 || FRAC >= WIDTH || FRAC < 0)
    begin : g_bad_param
        $error("fix_addsub_pipe: illegal parameter combination");
    end

    localparam logic signed [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    // Sign-extended sum; subtraction uses a + ~b + 1 so the most negative b
    // still produces the mathematically correct WIDTH+1 bit result.
    function automatic logic signed [WIDTH:0] sum_ext(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y,
        input logic                    neg
    );
        logic signed [WIDTH:0] xe;
        logic signed [WIDTH:0] ye;
        xe = {x[WIDTH-1], x};
        ye = {y[WIDTH-1], y};
        if (neg) begin
            return xe + (~ye) + ONE;
        end
        return xe + ye;
    endfunction

`ifdef FIX_ADDSUB_SAT_EN
    // Clamp an overflowing extended sum to the representable extreme whose
    // sign matches the true result (the extra top bit).
    function automatic logic [WIDTH-1:0] saturate(input logic signed [WIDTH:0] s);
        if (s[WIDTH] == s[WIDTH-1]) begin
            return s[WIDTH-1:0];
        end
        return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic [LANES*WIDTH-1:0] res_in;
    logic [LANES-1:0]       ovf_in;

    // ---- stage 0 arithmetic (combinational, registered into stage 0) ----
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WIDTH:0] s;
        assign s = sum_ext(bus.a[i*WIDTH +: WIDTH], bus.b[i*WIDTH +: WIDTH], bus.sub[i]);
        assign ovf_in[i] = s[WIDTH] ^ s[WIDTH-1];
`ifdef FIX_ADDSUB_SAT_EN
        assign res_in[i*WIDTH +: WIDTH] = saturate(s);
`else
        assign res_in[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
`endif
    end

    logic [STAGES-1:0]      vld_p;
    logic [LANES*WIDTH-1:0] res_p [STAGES];
    logic [LANES-1:0]       ovf_p [STAGES];
    logic [STAGES-1:0]      load;

    // Ready chain: a stage may load if it, or any stage downstream of it, is
    // empty, or the consumer takes the last stage this cycle.
    always_comb begin
        logic free;
        free = bus.out_rdy;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            free    = free || !vld_p[k];
            load[k] = free;
        end
    end

    assign bus.in_rdy  = load[0];
    assign bus.out_vld = vld_p[STAGES-1];
    assign bus.r       = res_p[STAGES-1];
    assign bus.ovf     = ovf_p[STAGES-1];

    // Pipeline registers: stage 0 captures the new beat, later stages shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_p[k] <= '0;
                ovf_p[k] <= '0;
            end
        end else begin
            // ---- stage 0 ----
            if (load[0]) begin
                vld_p[0] <= bus.in_vld;
                res_p[0] <= res_in;
                ovf_p[0] <= ovf_in;
            end
            // ---- stages 1..STAGES-1: pure delay ----
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    res_p[k] <= res_p[k-1];
                    ovf_p[k] <= ovf_p[k-1];
                end
            end
        end
    end

    logic ovf_event;
    assign ovf_event = bus.out_vld && bus.out_rdy && (|bus.ovf);

    // Overflow statistics: clear wins over a same-cycle event; counter saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (clr_stat) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (ovf_cnt != {CNT_W{1'b1}}) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fix_addsub_pipe.sv
// Directed bench for fix_addsub_pipe (WIDTH=16, LANES=2, STAGES=2, CNT_W=4).
// Expected values are hand-computed; build-dependent ones follow
// FIX_ADDSUB_SAT_EN.
module tb_fix_addsub_pipe;

`ifdef FIX_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       clr_stat;
    logic       ovf_sticky;
    logic [3:0] ovf_cnt;

    int n_vec;
    int n_err;

    fix_addsub_pipe_if #(.WIDTH(16), .LANES(2)) bus ();

    fix_addsub_pipe #(
        .WIDTH (16),
        .FRAC  (7),
        .LANES (2),
        .STAGES(2),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .clr_stat  (clr_stat),
        .ovf_sticky(ovf_sticky),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One isolated beat with out_rdy high; result expected one cycle after acceptance.
    task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [1:0] sv, input logic [31:0] er, input logic [1:0] eo);
        @(negedge clk);
        bus.in_vld = 1'b1;
        bus.a      = av;
        bus.b      = bv;
        bus.sub    = sv;
        #1 check({tag, "_in_rdy"}, 32'(bus.in_rdy), 32'd1);
        @(negedge clk);
        bus.in_vld = 1'b0;
        @(negedge clk);
        check({tag, "_out_vld"}, 32'(bus.out_vld), 32'd1);
        check({tag, "_r"}, bus.r, er);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    initial begin
        int sent;
        int got;
        int stale;
        n_vec        = 0;
        n_err        = 0;
        rstn         = 1'b0;
        clr_stat     = 1'b0;
        bus.in_vld   = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = '0;
        bus.out_rdy  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("rst_r", bus.r, 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_cnt", 32'(ovf_cnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rel_in_rdy", 32'(bus.in_rdy), 32'd1);

        // Basic add / subtract: lane0 1.5+2.25, lane1 -1.0-0.5
        run_one("basic", 32'hFF80_00C0, 32'h0040_0120, 2'b10, 32'hFF40_01E0, 2'b00);
        @(negedge clk);
        check("basic_cnt", 32'(ovf_cnt), 32'd0);

        // Positive overflow on lane0
        run_one("posovf", 32'h0000_7FFF, 32'h0000_0001, 2'b00,
                SAT ? 32'h0000_7FFF : 32'h0000_8000, 2'b01);
        @(negedge clk);
        check("posovf_sticky", 32'(ovf_sticky), 32'd1);
        check("posovf_cnt", 32'(ovf_cnt), 32'd1);

        // lane0: 0x8000-1 (negative ovf); lane1: 0-0x8000 (positive ovf)
        run_one("negovf", 32'h0000_8000, 32'h8000_0001, 2'b11,
                SAT ? 32'h7FFF_8000 : 32'h8000_7FFF, 2'b11);
        @(negedge clk);
        check("negovf_cnt", 32'(ovf_cnt), 32'd2);

        // Extremes that do not overflow: 0x7FFF+0x8000, 0x8000-0x8000
        run_one("edge", 32'h8000_7FFF, 32'h8000_8000, 2'b10, 32'h0000_FFFF, 2'b00);

        // Backpressure: 16 beats, out_rdy low for the first 6 cycles
        sent = 0;
        got  = 0;
        for (int c = 0; c < 100 && got < 16; c++) begin
            @(negedge clk);
            bus.out_rdy = (c >= 6);
            bus.in_vld  = (sent < 16);
            bus.a       = {16'(sent + 1), 16'(sent + 1)};
            bus.b       = '0;
            bus.sub     = '0;
            #1;
            if (c == 5) begin
                check("bp_accepted", 32'(sent), 32'd2);
                check("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
                check("bp_out_vld", 32'(bus.out_vld), 32'd1);
                check("bp_r_held", bus.r, 32'h0001_0001);
            end
            if (bus.in_vld && bus.in_rdy) sent++;
            if (bus.out_vld && bus.out_rdy) begin
                check("bp_r", bus.r, {16'(got + 1), 16'(got + 1)});
                got++;
            end
        end
        bus.in_vld = 1'b0;
        check("bp_count", 32'(got), 32'd16);
        @(negedge clk);
        check("bp_drained", 32'(bus.out_vld), 32'd0);

        // Statistics: clear, then 20 overflowing beats saturate a 4-bit counter
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        #1;
        check("clr_cnt", 32'(ovf_cnt), 32'd0);
        check("clr_sticky", 32'(ovf_sticky), 32'd0);
        bus.in_vld = 1'b1;
        bus.a      = 32'h0000_7FFF;
        bus.b      = 32'h0000_0001;
        bus.sub    = 2'b00;
        repeat (20) @(negedge clk);
        bus.in_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_cnt", 32'(ovf_cnt), 32'hF);
        check("sat_sticky", 32'(ovf_sticky), 32'd1);

        // clr_stat coincident with an overflowing output transfer
        bus.in_vld = 1'b1;
        @(negedge clk);
        bus.in_vld = 1'b0;
        @(negedge clk);
        check("clrev_out_vld", 32'(bus.out_vld), 32'd1);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check("clrev_cnt", 32'(ovf_cnt), 32'd0);
        check("clrev_sticky", 32'(ovf_sticky), 32'd0);

        // Reset with two beats in flight
        bus.out_rdy = 1'b0;
        bus.a       = 32'h0005_0005;
        bus.b       = '0;
        bus.in_vld  = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_vld = 1'b0;
        #1;
        check("mid_full", 32'(bus.in_rdy), 32'd0);
        check("mid_out_vld_pre", 32'(bus.out_vld), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_out_vld", 32'(bus.out_vld), 32'd0);
        check("mid_r", bus.r, 32'd0);
        check("mid_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rstn        = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        check("mid_in_rdy", 32'(bus.in_rdy), 32'd1);
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.out_vld) stale++;
        end
        check("mid_stale", 32'(stale), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
